// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 @ 60 Hz VGA timing constants and sync/visible-area decode helpers.
// Shared by vga_sync and anything downstream that needs the raster geometry.
package vga_timing_pkg;

    // Width of the x/y raster counters.
    localparam int unsigned CNT_W     = 10;

    // Horizontal timing, in pixels.
    localparam int unsigned H_DISP    = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOT     = H_DISP + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines.
    localparam int unsigned V_DISP    = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOT     = V_DISP + V_FP + V_SYNC + V_BP;

    // Line on which the once-per-frame game update strobe fires.
    localparam int unsigned TICK_LINE = 481;

    // True while x lies in the hsync pulse [h_start, h_start+h_width).
    function automatic logic in_hsync(input logic [CNT_W-1:0] x,
                                      input int unsigned      h_start,
                                      input int unsigned      h_width);
        return (x >= CNT_W'(h_start)) && (x < CNT_W'(h_start + h_width));
    endfunction

    // True while y lies in the vsync pulse [v_start, v_start+v_width).
    function automatic logic in_vsync(input logic [CNT_W-1:0] y,
                                      input int unsigned      v_start,
                                      input int unsigned      v_width);
        return (y >= CNT_W'(v_start)) && (y < CNT_W'(v_start + v_width));
    endfunction

    // True while (x,y) is inside the visible area.
    function automatic logic visible(input logic [CNT_W-1:0] x,
                                     input logic [CNT_W-1:0] y,
                                     input int unsigned      h_disp,
                                     input int unsigned      v_disp);
        return (x < CNT_W'(h_disp)) && (y < CNT_W'(v_disp));
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides the system clock down to a one-clock pixel enable.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   p_tick - registered pulse, high one clock in every DIV (constant 1 after reset when DIV=1)
module pixel_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;
    logic          p_tick_q;

    // Wrapping 0..DIV-1 counter.
    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end
    end

    // p_tick is the registered decode of the terminal count, so the first
    // enable after reset lands on the DIV-th clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= (div_cnt_q == LAST);
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync.sv
// vga_sync: VGA raster timing generator (default 640x480 @ 60 Hz from a 100 MHz clock).
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   hsync, vsync - active-low sync pulses for the board pins
//   display_on   - high while (x,y) is in the visible area
//   p_tick       - pixel enable, one clock in every DIV
//   frame_tick   - one-clock strobe on the first clock of (0, TICK_LINE)
//   x, y         - current pixel / line counters
// All outputs are registered and aligned with the x,y being presented.
module vga_sync #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned H_DISP    = vga_timing_pkg::H_DISP,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_DISP    = vga_timing_pkg::V_DISP,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
    parameter int unsigned TICK_LINE = vga_timing_pkg::TICK_LINE
) (
    input  logic       clock,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       p_tick,
    output logic       frame_tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned VS_START = V_DISP + V_FP;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_STROBE = CNT_W'(TICK_LINE);

    logic             p_tick_w;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hsync_q;
    logic             vsync_q;
    logic             display_on_q;
    logic             frame_tick_q;

    pixel_tick_gen #(
        .DIV    (DIV)
    ) u_pixel_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .p_tick (p_tick_w)
    );

    // Raster counters advance only on pixel enables.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick_w) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
    end

    // Decodes come from the next-state counters so they never lag x,y.
    // frame_tick needs p_tick as well so it fires only on entry to (0,TICK_LINE),
    // not on the DIV-1 clocks that pixel is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            display_on_q <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            hsync_q      <= ~in_hsync(x_d, HS_START, H_SYNC);
            vsync_q      <= ~in_vsync(y_d, VS_START, V_SYNC);
            display_on_q <= visible(x_d, y_d, H_DISP, V_DISP);
            frame_tick_q <= p_tick_w && (x_d == '0) && (y_d == Y_STROBE);
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = display_on_q;
    assign p_tick     = p_tick_w;
    assign frame_tick = frame_tick_q;
    assign x          = x_q;
    assign y          = y_q;

endmodule
